// File: rtl/wb_tester_pkg.sv
// Shared types and constants for the Wishbone block tester.
package wb_tester_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        GAP,
        RD,
        FIN
    } state_t;

    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_MISMATCH = 2'd1,
        ST_BUS_ERR  = 2'd2,
        ST_TIMEOUT  = 2'd3
    } status_t;

    localparam logic [3:0] SEL_ALL = 4'hF;

endpackage

// File: rtl/wshb_if.sv
// Wishbone classic bus bundle shared by masters and BlockRAM slaves.
interface wshb_if (
    input logic clk,
    input logic rst
);

    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic        ack;
    logic        err;
    logic        rty;

    modport master (
        input  clk, rst, dat_sm, ack, err, rty,
        output cyc, stb, we, adr, sel, dat_ms
    );

    modport slave (
        input  clk, rst, cyc, stb, we, adr, sel, dat_ms,
        output dat_sm, ack, err, rty
    );

endinterface

// File: rtl/wb_watchdog.sv
// Counts silent strobe cycles; expired flags the cycle in which TIMEOUT is reached.
module wb_watchdog #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic kick,
    output logic expired
);

    localparam int unsigned W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt;

    assign expired = active && !kick && (cnt == W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || !active || kick) begin
            cnt <= '0;
        end else if (!expired) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/wb_block_tester.sv
// Wishbone classic master: writes seed+i to a block, reads it back and counts mismatches.
module wb_block_tester
    import wb_tester_pkg::*;
#(
    parameter int unsigned CNT_W   = 12,
    parameter int unsigned TIMEOUT = 256
) (
    wshb_if.master           wb_m,
    input  logic             start,
    input  logic [31:0]      base_adr,
    input  logic [CNT_W-1:0] word_cnt,
    input  logic [31:0]      seed,
    output logic             busy,
    output logic             done,
    output logic [1:0]       status,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [31:0]      first_err_adr
);

    state_t           state, state_n;
    status_t          status_q, status_n;
    logic [31:0]      base_q, base_n, seed_q, seed_n;
    logic [CNT_W-1:0] cnt_q, cnt_n, idx_q, idx_n, mm_q, mm_n;
    logic [31:0]      adr_q, adr_n, dat_q, dat_n, fea_q, fea_n;
    logic             cyc_q, cyc_n, stb_q, stb_n, we_q, we_n;
    logic             busy_q, busy_n, done_q, done_n;
    logic             expired, last;

    assign wb_m.cyc      = cyc_q;
    assign wb_m.stb      = stb_q;
    assign wb_m.we       = we_q;
    assign wb_m.adr      = adr_q;
    assign wb_m.sel      = SEL_ALL;
    assign wb_m.dat_ms   = dat_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign status        = status_q;
    assign mismatch_cnt  = mm_q;
    assign first_err_adr = fea_q;

    assign last = (idx_q == cnt_q - CNT_W'(1));

    wb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (wb_m.clk),
        .rst     (wb_m.rst),
        .active  (stb_q),
        .kick    (wb_m.ack || wb_m.err || wb_m.rty),
        .expired (expired)
    );

    always_comb begin
        state_n  = state;
        status_n = status_q;
        base_n   = base_q;
        seed_n   = seed_q;
        cnt_n    = cnt_q;
        idx_n    = idx_q;
        mm_n     = mm_q;
        adr_n    = adr_q;
        dat_n    = dat_q;
        fea_n    = fea_q;
        cyc_n    = cyc_q;
        stb_n    = stb_q;
        we_n     = we_q;
        busy_n   = busy_q;
        done_n   = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    base_n   = {base_adr[31:2], 2'b00};
                    seed_n   = seed;
                    cnt_n    = word_cnt;
                    idx_n    = '0;
                    adr_n    = {base_adr[31:2], 2'b00};
                    dat_n    = seed;
                    mm_n     = '0;
                    fea_n    = '0;
                    status_n = ST_OK;
                    busy_n   = 1'b1;
                    if (word_cnt == '0) begin
                        state_n = FIN;
                    end else begin
                        state_n = WR;
                        cyc_n   = 1'b1;
                        stb_n   = 1'b1;
                        we_n    = 1'b1;
                    end
                end
            end
            // Reads reuse dat_q as the expected pattern value.
            WR, RD: begin
                if (!stb_q) begin
                    stb_n = 1'b1;
                end else if (wb_m.ack) begin
                    if (state == RD && wb_m.dat_sm != dat_q) begin
                        if (mm_q != '1) mm_n = mm_q + CNT_W'(1);
                        if (mm_q == '0) fea_n = adr_q;
                    end
                    if (last) begin
                        cyc_n   = 1'b0;
                        stb_n   = 1'b0;
                        we_n    = 1'b0;
                        state_n = (state == WR) ? GAP : FIN;
                    end else begin
                        idx_n = idx_q + CNT_W'(1);
                        adr_n = adr_q + 32'd4;
                        dat_n = dat_q + 32'd1;
                    end
                end else if (wb_m.err || expired) begin
                    cyc_n    = 1'b0;
                    stb_n    = 1'b0;
                    we_n     = 1'b0;
                    status_n = wb_m.err ? ST_BUS_ERR : ST_TIMEOUT;
                    state_n  = FIN;
                end else if (wb_m.rty) begin
                    stb_n = 1'b0;
                end
            end
            GAP: begin
                state_n = RD;
                cyc_n   = 1'b1;
                stb_n   = 1'b1;
                we_n    = 1'b0;
                idx_n   = '0;
                adr_n   = base_q;
                dat_n   = seed_q;
            end
            FIN: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                if (status_q == ST_OK && mm_q != '0) status_n = ST_MISMATCH;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge wb_m.clk) begin
        if (wb_m.rst) begin
            state    <= IDLE;
            status_q <= ST_OK;
            base_q   <= '0;
            seed_q   <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            mm_q     <= '0;
            adr_q    <= '0;
            dat_q    <= '0;
            fea_q    <= '0;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            status_q <= status_n;
            base_q   <= base_n;
            seed_q   <= seed_n;
            cnt_q    <= cnt_n;
            idx_q    <= idx_n;
            mm_q     <= mm_n;
            adr_q    <= adr_n;
            dat_q    <= dat_n;
            fea_q    <= fea_n;
            cyc_q    <= cyc_n;
            stb_q    <= stb_n;
            we_q     <= we_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
        end
    end

endmodule

// File: tb/tb_wb_block_tester.sv
// Directed bench: configurable slave, transaction-level expectation queue and result model.
module tb_wb_block_tester;
    import wb_tester_pkg::*;

    localparam int unsigned CNT_W = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wshb_if wb (.clk(clk), .rst(rst));

    logic             start = 1'b0;
    logic [31:0]      base_adr = '0;
    logic [31:0]      seed = '0;
    logic [CNT_W-1:0] word_cnt = '0;
    logic             busy, done;
    logic [1:0]       status;
    logic [CNT_W-1:0] mismatch_cnt;
    logic [31:0]      first_err_adr;

    wb_block_tester #(.CNT_W(CNT_W), .TIMEOUT(16)) dut (
        .wb_m          (wb.master),
        .start         (start),
        .base_adr      (base_adr),
        .word_cnt      (word_cnt),
        .seed          (seed),
        .busy          (busy),
        .done          (done),
        .status        (status),
        .mismatch_cnt  (mismatch_cnt),
        .first_err_adr (first_err_adr)
    );

    // Slave behaviour knobs, set only by the stimulus process.
    bit          pace = 1'b0, silent = 1'b0, err_en = 1'b0, corrupt_en = 1'b0;
    logic [31:0] err_adr = '0, rty_adr = '0, corrupt_adr = '0;
    int          rty_limit = 0;
    int          rty_cnt = 0;
    logic        phase = 1'b0;
    logic [31:0] mem [256];

    always_comb begin
        wb.ack    = 1'b0;
        wb.err    = 1'b0;
        wb.rty    = 1'b0;
        wb.dat_sm = mem[wb.adr[9:2]];
        if (corrupt_en && !wb.we && wb.adr == corrupt_adr) wb.dat_sm = mem[wb.adr[9:2]] ^ 32'h1;
        if (wb.cyc && wb.stb && !silent) begin
            if (err_en && wb.adr == err_adr)                          wb.err = 1'b1;
            else if (rty_cnt < rty_limit && wb.we && wb.adr == rty_adr) wb.rty = 1'b1;
            else if (!wb.we && pace)                                  wb.ack = phase;
            else                                                      wb.ack = 1'b1;
        end
    end

    always @(posedge clk) begin
        phase <= (wb.cyc && wb.stb && !wb.we && pace) ? !phase : 1'b0;
        if (wb.cyc && wb.stb && wb.we && wb.ack) mem[wb.adr[9:2]] <= wb.dat_ms;
        if (wb.rty) rty_cnt <= rty_cnt + 1;
    end

    // Model: the bus accesses a command must produce and the results it must report.
    typedef struct {
        bit          we;
        logic [31:0] adr;
        logic [31:0] dat;
    } acc_t;

    acc_t             exp_q[$];
    logic [1:0]       exp_status;
    logic [CNT_W-1:0] exp_mm;
    logic [31:0]      exp_fea;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic predict(input logic [31:0] b, input int n, input logic [31:0] s, input int err_i);
        logic [31:0] a;
        b          = b & 32'hFFFF_FFFC;
        exp_q.delete();
        exp_mm     = '0;
        exp_fea    = '0;
        exp_status = ST_OK;
        if (silent) begin
            exp_status = ST_TIMEOUT;
            return;
        end
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{1'b1, b + 32'(i) * 32'd4, s + 32'(i)});
            if (i == err_i) begin
                exp_status = ST_BUS_ERR;
                return;
            end
        end
        for (int i = 0; i < n; i++) begin
            a = b + 32'(i) * 32'd4;
            exp_q.push_back('{1'b0, a, s + 32'(i)});
            if (corrupt_en && a == corrupt_adr) begin
                if (exp_mm == '0) exp_fea = a;
                exp_mm = exp_mm + CNT_W'(1);
            end
        end
        if (exp_mm != '0) exp_status = ST_MISMATCH;
    endtask

    int stb_cycles = 0, rd_cycles = 0, cyc_cycles = 0;
    bit err_last = 1'b0, rty_last = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            err_last = 1'b0;
            rty_last = 1'b0;
        end else begin
            if (err_last) check("cyc dropped after err", wb.cyc, 0);
            if (rty_last) begin
                check("cyc held in retry gap", wb.cyc, 1);
                check("stb low in retry gap", wb.stb, 0);
            end
            err_last = 1'b0;
            rty_last = 1'b0;
            if (wb.stb) stb_cycles++;
            if (wb.cyc) cyc_cycles++;
            if (wb.cyc && wb.stb && !wb.we) rd_cycles++;
            if (wb.cyc && exp_q.size() == 0 && !silent) check("unexpected bus cycle", wb.cyc, 0);
            if (wb.cyc && wb.stb && (wb.ack || wb.err || wb.rty) && exp_q.size() > 0) begin
                check("access we", wb.we, exp_q[0].we);
                check("access adr", wb.adr, exp_q[0].adr);
                check("access sel", wb.sel, 4'hF);
                if (exp_q[0].we) check("write data", wb.dat_ms, exp_q[0].dat);
                if (wb.rty) rty_last = 1'b1;
                else begin
                    void'(exp_q.pop_front());
                    if (wb.err) err_last = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int lat, snap_stb, snap_rd, snap_cyc, snap_rty;

    task automatic launch(input logic [31:0] b, input int n, input logic [31:0] s, input int err_i);
        predict(b, n, s, err_i);
        snap_stb = stb_cycles;
        snap_rd  = rd_cycles;
        snap_cyc = cyc_cycles;
        snap_rty = rty_cnt;
        base_adr = b;
        word_cnt = CNT_W'(n);
        seed     = s;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        lat      = 1;
        check("busy after start", busy, 1);
    endtask

    task automatic finish();
        while (!done && lat < 3000) begin
            tick();
            lat++;
        end
        check("done within budget", done, 1);
        check("busy low with done", busy, 0);
        check("status vs model", status, exp_status);
        check("mismatch_cnt vs model", mismatch_cnt, exp_mm);
        check("first_err_adr vs model", first_err_adr, exp_fea);
        check("all accesses seen", exp_q.size(), 0);
        tick();
        check("done is one cycle", done, 0);
    endtask

    initial begin
        repeat (3) tick();
        check("rst cyc", wb.cyc, 0);
        check("rst stb", wb.stb, 0);
        check("rst we", wb.we, 0);
        check("rst adr", wb.adr, 0);
        check("rst dat_ms", wb.dat_ms, 0);
        check("rst sel", wb.sel, 4'hF);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst status", status, 0);
        check("rst mismatch_cnt", mismatch_cnt, 0);
        check("rst first_err_adr", first_err_adr, 0);
        rst = 1'b0;
        tick();

        // Paced reads: one ack per two cycles.
        pace = 1'b1;
        launch(32'h0, 8, 32'h100, -1);
        finish();
        check("mem[0]", mem[0], 32'h100);
        check("mem[7]", mem[7], 32'h107);
        check("read stb cycles paced", rd_cycles - snap_rd, 16);
        check("clean status", status, 0);

        // Empty block: done two cycles after start, no bus activity.
        pace = 1'b0;
        launch(32'h300, 0, 32'h1, -1);
        finish();
        check("zero-count done latency", lat, 2);
        check("zero-count cyc cycles", cyc_cycles - snap_cyc, 0);

        // Corrupted read at 0x4C.
        corrupt_en  = 1'b1;
        corrupt_adr = 32'h4C;
        launch(32'h40, 8, 32'hA000, -1);
        finish();
        check("corrupt mismatch_cnt", mismatch_cnt, 1);
        check("corrupt first_err_adr", first_err_adr, 32'h4C);
        check("corrupt status", status, 1);
        corrupt_en = 1'b0;

        // Bus error on second write; base bits [1:0] ignored.
        err_en  = 1'b1;
        err_adr = 32'h84;
        launch(32'h83, 8, 32'h55, 1);
        finish();
        check("err status", status, 2);
        check("err no reads", rd_cycles - snap_rd, 0);
        err_en = 1'b0;

        // Silent slave, then a normal run with seed wrapping.
        silent = 1'b1;
        launch(32'h100, 5, 32'h0, -1);
        finish();
        check("timeout status", status, 3);
        check("timeout stb cycles", stb_cycles - snap_stb, 16);
        silent = 1'b0;
        launch(32'hC0, 4, 32'hFFFF_FFFE, -1);
        finish();
        check("recovery status", status, 0);
        check("wrapped pattern", mem[51], 32'h1);

        // Retry on write 3 and a start pulse while busy.
        rty_adr   = 32'h2C;
        rty_limit = rty_cnt + 1;
        launch(32'h20, 6, 32'h700, -1);
        tick();
        tick();
        base_adr = 32'h200;
        word_cnt = CNT_W'(3);
        start    = 1'b1;
        tick();
        start    = 1'b0;
        lat      = lat + 3;
        finish();
        check("rty seen once", rty_cnt - snap_rty, 1);
        check("retry status", status, 0);
        check("retried word", mem[11], 32'h703);
        repeat (4) tick();
        check("ignored start idle cyc", wb.cyc, 0);

        // Reset during the read phase.
        pace        = 1'b1;
        corrupt_en  = 1'b1;
        corrupt_adr = 32'h40;
        launch(32'h40, 8, 32'h9, -1);
        while (mismatch_cnt == '0 && lat < 300) begin
            tick();
            lat++;
        end
        check("mid-read mismatch seen", mismatch_cnt, 1);
        rst = 1'b1;
        tick();
        exp_q.delete();
        check("mid rst cyc", wb.cyc, 0);
        check("mid rst stb", wb.stb, 0);
        check("mid rst adr", wb.adr, 0);
        check("mid rst busy", busy, 0);
        check("mid rst status", status, 0);
        check("mid rst mismatch_cnt", mismatch_cnt, 0);
        check("mid rst first_err_adr", first_err_adr, 0);
        rst        = 1'b0;
        corrupt_en = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
